// File: rtl/rf_wport_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_wport_arbiter_pkg;

  localparam logic [3:0] RF_WE_FULL  = 4'b1111;
  localparam logic [4:0] RF_ZERO_REG = 5'd0;

  // One buffered late result: destination register and full-word data.
  typedef struct packed {
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } rf_entry_t;

  // Which requester owns the write port in the current cycle.
  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_FIFO = 2'd2
  } grant_e;

endpackage

// File: rtl/rf_late_fifo.sv
// Small FIFO holding late mul/div results until the write port is free.
// Exposes a per-slot valid/wnum view so the top can run the pending-write
// scoreboard against everything still queued.
module rf_late_fifo
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [4:0]               push_wnum_i,
  input  logic [31:0]              push_wdata_i,
  input  logic                     pop_i,
  output logic [4:0]               head_wnum_o,
  output logic [31:0]              head_wdata_o,
  output logic [$clog2(DEPTH):0]   cnt_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [DEPTH-1:0]         ent_valid_o,
  output logic [DEPTH*5-1:0]       ent_wnum_o
);

  localparam int AW = $clog2(DEPTH);

  rf_entry_t        mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  // Guard against misuse so pointers and count can never drift apart.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  assign head_wnum_o  = mem_q[rd_ptr_q].wnum;
  assign head_wdata_o = mem_q[rd_ptr_q].wdata;
  assign cnt_o        = cnt_q;
  assign ent_valid_o  = vld_q;

  // Flatten the stored destination numbers for the scoreboard compare.
  always_comb begin
    ent_wnum_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_wnum_o[i*5 +: 5] = mem_q[i].wnum;
    end
  end

  // Next pointers, count and slot-valid bits; pointers wrap modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    vld_d    = vld_q;
    if (pop_ok) begin
      rd_ptr_d        = rd_ptr_q + AW'(1);
      vld_d[rd_ptr_q] = 1'b0;
    end
    if (push_ok) begin
      wr_ptr_d        = wr_ptr_q + AW'(1);
      vld_d[wr_ptr_q] = 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; reset drops every queued entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
    end
  end

  // Storage array; contents are qualified by vld_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= '{wnum: push_wnum_i, wdata: push_wdata_i};
    end
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Arbiter for the single register-file write port: WB writeback versus
// buffered late mul/div results, with an anti-starvation limit on WB wins
// and a pending-write lookup for ID.
//
// Handshakes: the late-result side is valid/ready; a beat transfers when
// md_valid_in && md_ready_out at the clock edge, and md_ready_out depends
// only on current occupancy. WB has no ready; instead wb_stall_out tells WB
// to hold its inputs unchanged for another cycle.
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wb_valid_in,
  input  logic [3:0]             wb_we_in,
  input  logic [4:0]             wb_wnum_in,
  input  logic [31:0]            wb_wdata_in,
  output logic                   wb_stall_out,
  input  logic                   md_valid_in,
  input  logic [4:0]             md_wnum_in,
  input  logic [31:0]            md_wdata_in,
  output logic                   md_ready_out,
  input  logic [4:0]             id_rnum0_in,
  input  logic [4:0]             id_rnum1_in,
  input  logic [4:0]             id_wnum_in,
  output logic                   id_pending_hit_out,
  output logic [3:0]             rf_we_out,
  output logic [4:0]             rf_wnum_out,
  output logic [31:0]            rf_wdata_out,
  output logic [$clog2(DEPTH):0] fifo_cnt_out
);

  logic               wb_req;
  logic               md_push;
  logic               fifo_full, fifo_empty;
  logic [4:0]         head_wnum;
  logic [31:0]        head_wdata;
  logic [DEPTH-1:0]   ent_valid;
  logic [DEPTH*5-1:0] ent_wnum;
  grant_e             grant;
  logic [3:0]         starve_q, starve_d;
  logic [3:0]         rf_we_q, rf_we_d;
  logic [4:0]         rf_wnum_q, rf_wnum_d;
  logic [31:0]        rf_wdata_q, rf_wdata_d;

  // A WB instruction only competes if it actually writes a real register.
  assign wb_req = wb_valid_in && (|wb_we_in) && (wb_wnum_in != RF_ZERO_REG);

  // No same-cycle credit for a pop: ready reflects current occupancy only.
  assign md_ready_out = !fifo_full;
  // Results aimed at r0 are acknowledged but never stored.
  assign md_push = md_valid_in && md_ready_out && (md_wnum_in != RF_ZERO_REG);

  rf_late_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (md_push),
    .push_wnum_i  (md_wnum_in),
    .push_wdata_i (md_wdata_in),
    .pop_i        (grant == GNT_FIFO),
    .head_wnum_o  (head_wnum),
    .head_wdata_o (head_wdata),
    .cnt_o        (fifo_cnt_out),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .ent_valid_o  (ent_valid),
    .ent_wnum_o   (ent_wnum)
  );

  // Grant selection: WB first, but the queue wins after STARVE_MAX straight WB grants.
  always_comb begin
    grant = GNT_IDLE;
    if (fifo_empty) begin
      if (wb_req) grant = GNT_WB;
    end else if (!wb_req) begin
      grant = GNT_FIFO;
    end else if (starve_q < 4'(STARVE_MAX)) begin
      grant = GNT_WB;
    end else begin
      grant = GNT_FIFO;
    end
  end

  assign wb_stall_out = wb_req && (grant != GNT_WB);

  // Starvation counter: counts WB wins only while something is waiting.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || grant == GNT_FIFO) begin
      starve_d = 4'd0;
    end else if (grant == GNT_WB) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Next value of the registered write port; address/data hold when idle.
  always_comb begin
    rf_we_d    = 4'b0000;
    rf_wnum_d  = rf_wnum_q;
    rf_wdata_d = rf_wdata_q;
    case (grant)
      GNT_WB: begin
        rf_we_d    = wb_we_in;
        rf_wnum_d  = wb_wnum_in;
        rf_wdata_d = wb_wdata_in;
      end
      GNT_FIFO: begin
        rf_we_d    = RF_WE_FULL;
        rf_wnum_d  = head_wnum;
        rf_wdata_d = head_wdata;
      end
      default: ;
    endcase
  end

  // Write-port and starvation registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q   <= 4'd0;
      rf_we_q    <= 4'b0000;
      rf_wnum_q  <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_wnum_q  <= rf_wnum_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we_out    = rf_we_q;
  assign rf_wnum_out  = rf_wnum_q;
  assign rf_wdata_out = rf_wdata_q;

  // Pending-write lookup: any non-zero query matching an occupied slot.
  always_comb begin
    id_pending_hit_out = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) begin
        if (id_rnum0_in != RF_ZERO_REG && ent_wnum[i*5 +: 5] == id_rnum0_in) id_pending_hit_out = 1'b1;
        if (id_rnum1_in != RF_ZERO_REG && ent_wnum[i*5 +: 5] == id_rnum1_in) id_pending_hit_out = 1'b1;
        if (id_wnum_in  != RF_ZERO_REG && ent_wnum[i*5 +: 5] == id_wnum_in)  id_pending_hit_out = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Bench for rf_wport_arbiter (DEPTH=2, STARVE_MAX=4).
module tb_rf_wport_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid_in;
  logic [3:0]  wb_we_in;
  logic [4:0]  wb_wnum_in;
  logic [31:0] wb_wdata_in;
  logic        wb_stall_out;
  logic        md_valid_in;
  logic [4:0]  md_wnum_in;
  logic [31:0] md_wdata_in;
  logic        md_ready_out;
  logic [4:0]  id_rnum0_in, id_rnum1_in, id_wnum_in;
  logic        id_pending_hit_out;
  logic [3:0]  rf_we_out;
  logic [4:0]  rf_wnum_out;
  logic [31:0] rf_wdata_out;
  logic [1:0]  fifo_cnt_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected register-file writes in issue order: {we, wnum, wdata}.
  logic [40:0] exp_q[$];
  // Late results the bench expects to be sitting in the queue: {wnum, wdata}.
  logic [36:0] md_model_q[$];
  logic [40:0] mon_exp;

  rf_wport_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .wb_valid_in        (wb_valid_in),
    .wb_we_in           (wb_we_in),
    .wb_wnum_in         (wb_wnum_in),
    .wb_wdata_in        (wb_wdata_in),
    .wb_stall_out       (wb_stall_out),
    .md_valid_in        (md_valid_in),
    .md_wnum_in         (md_wnum_in),
    .md_wdata_in        (md_wdata_in),
    .md_ready_out       (md_ready_out),
    .id_rnum0_in        (id_rnum0_in),
    .id_rnum1_in        (id_rnum1_in),
    .id_wnum_in         (id_wnum_in),
    .id_pending_hit_out (id_pending_hit_out),
    .rf_we_out          (rf_we_out),
    .rf_wnum_out        (rf_wnum_out),
    .rf_wdata_out       (rf_wdata_out),
    .fifo_cnt_out       (fifo_cnt_out)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Write monitor: every observed write must match the head of exp_q.
  always @(negedge clk) begin
    if (rst_n && rf_we_out != 4'b0000) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rf_write_unexpected: got we=%h wnum=%0d data=%h, required no write",
                 rf_we_out, rf_wnum_out, rf_wdata_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({rf_we_out, rf_wnum_out, rf_wdata_out} !== mon_exp) begin
          n_fail++;
          $display("FAIL rf_write: got we=%h wnum=%0d data=%h, required we=%h wnum=%0d data=%h",
                   rf_we_out, rf_wnum_out, rf_wdata_out,
                   mon_exp[40:37], mon_exp[36:32], mon_exp[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid_in = 1'b0; wb_we_in = 4'h0; wb_wnum_in = 5'd0; wb_wdata_in = 32'd0;
    md_valid_in = 1'b0; md_wnum_in = 5'd0; md_wdata_in = 32'd0;
    id_rnum0_in = 5'd0; id_rnum1_in = 5'd0; id_wnum_in = 5'd0;
  endtask

  task automatic drive_wb(input logic v, input logic [3:0] we, input logic [4:0] wn, input logic [31:0] wd);
    wb_valid_in = v; wb_we_in = we; wb_wnum_in = wn; wb_wdata_in = wd;
  endtask

  typedef struct {
    logic        v;
    logic [3:0]  we;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic        e_stall;
    logic [3:0]  e_we;
    logic [4:0]  e_wnum;
    logic [31:0] e_wdata;
  } wb_vec_t;

  typedef struct {
    logic       wbv;
    logic       mdv;
    logic       e_ready;
    logic [1:0] e_cnt;
    logic       e_pop;
  } fill_vec_t;

  wb_vec_t   vecs[7];
  fill_vec_t fills[9];
  logic      starve_exp[7];

  initial begin
    // WB-only vectors; expected rf_* appear one cycle after the drive.
    vecs[0] = '{1'b1, 4'hF, 5'd5,  32'h1234_5678, 1'b0, 4'hF, 5'd5,  32'h1234_5678};
    vecs[1] = '{1'b1, 4'h3, 5'd7,  32'hA5A5_0001, 1'b0, 4'h3, 5'd7,  32'hA5A5_0001};
    vecs[2] = '{1'b0, 4'hF, 5'd9,  32'h1111_1111, 1'b0, 4'h0, 5'd7,  32'hA5A5_0001};
    vecs[3] = '{1'b1, 4'h0, 5'd9,  32'h2222_2222, 1'b0, 4'h0, 5'd7,  32'hA5A5_0001};
    vecs[4] = '{1'b1, 4'hF, 5'd0,  32'h3333_3333, 1'b0, 4'h0, 5'd7,  32'hA5A5_0001};
    vecs[5] = '{1'b1, 4'h8, 5'd31, 32'hCAFE_F00D, 1'b0, 4'h8, 5'd31, 32'hCAFE_F00D};
    vecs[6] = '{1'b1, 4'h1, 5'd1,  32'h0000_0000, 1'b0, 4'h1, 5'd1,  32'h0000_0000};

    // Fill/wrap sequence: per cycle {wb active, md offered, ready, count, pop}.
    fills[0] = '{1'b1, 1'b1, 1'b1, 2'd0, 1'b0};
    fills[1] = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b0};
    fills[2] = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b0};
    fills[3] = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b1};
    fills[4] = '{1'b0, 1'b1, 1'b1, 2'd1, 1'b1};
    fills[5] = '{1'b0, 1'b1, 1'b1, 2'd1, 1'b1};
    fills[6] = '{1'b0, 1'b1, 1'b1, 2'd1, 1'b1};
    fills[7] = '{1'b0, 1'b1, 1'b1, 2'd1, 1'b1};
    fills[8] = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1};

    starve_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // ---- reset, with a WB request present ----
    idle_inputs();
    rst_n = 1'b0;
    drive_wb(1'b1, 4'hF, 5'd5, 32'h1234_5678);
    repeat (2) @(posedge clk);
    #1;
    check("reset_rf_we", rf_we_out, 4'h0);
    check("reset_rf_wnum", rf_wnum_out, 5'd0);
    check("reset_rf_wdata", rf_wdata_out, 32'd0);
    check("reset_cnt", fifo_cnt_out, 2'd0);
    check("reset_ready", md_ready_out, 1'b1);
    check("reset_stall", wb_stall_out, 1'b0);
    idle_inputs();
    rst_n = 1'b1;
    tick();

    // ---- WB-only table ----
    for (int i = 0; i < 7; i++) begin
      drive_wb(vecs[i].v, vecs[i].we, vecs[i].wnum, vecs[i].wdata);
      if (vecs[i].e_we != 4'h0) exp_q.push_back({vecs[i].e_we, vecs[i].e_wnum, vecs[i].e_wdata});
      @(negedge clk);
      check($sformatf("wb_vec%0d_stall", i), wb_stall_out, vecs[i].e_stall);
      tick();
      check($sformatf("wb_vec%0d_we", i), rf_we_out, vecs[i].e_we);
      check($sformatf("wb_vec%0d_wnum", i), rf_wnum_out, vecs[i].e_wnum);
      check($sformatf("wb_vec%0d_wdata", i), rf_wdata_out, vecs[i].e_wdata);
    end
    idle_inputs();
    tick();

    // ---- single late result r9, WB idle ----
    md_valid_in = 1'b1; md_wnum_in = 5'd9; md_wdata_in = 32'hDEAD_BEEF;
    exp_q.push_back({4'hF, 5'd9, 32'hDEAD_BEEF});
    @(negedge clk);
    check("md9_ready", md_ready_out, 1'b1);
    tick();
    md_valid_in = 1'b0;
    id_rnum0_in = 5'd9;
    #1;
    check("md9_cnt_after_push", fifo_cnt_out, 2'd1);
    check("md9_no_bypass", rf_we_out, 4'h0);
    check("md9_hit_rnum0", id_pending_hit_out, 1'b1);
    id_rnum0_in = 5'd0; id_wnum_in = 5'd9;
    #1;
    check("md9_hit_wnum", id_pending_hit_out, 1'b1);
    id_wnum_in = 5'd0; id_rnum1_in = 5'd8;
    #1;
    check("md9_miss_r8", id_pending_hit_out, 1'b0);
    id_rnum1_in = 5'd9;
    tick();
    check("md9_rf_we", rf_we_out, 4'hF);
    check("md9_rf_wnum", rf_wnum_out, 5'd9);
    check("md9_rf_wdata", rf_wdata_out, 32'hDEAD_BEEF);
    check("md9_cnt_after_pop", fifo_cnt_out, 2'd0);
    check("md9_hit_cleared", id_pending_hit_out, 1'b0);
    idle_inputs();

    // ---- starvation limit: one queued entry, WB requesting every cycle ----
    md_valid_in = 1'b1; md_wnum_in = 5'd12; md_wdata_in = 32'h0C0C_0C0C;
    tick();
    md_valid_in = 1'b0;
    begin
      int idx;
      idx = 0;
      for (int c = 0; c < 7; c++) begin
        drive_wb(1'b1, 4'hF, 5'd3, 32'hB000_0000 + 32'(idx));
        @(negedge clk);
        check($sformatf("starve_c%0d_stall", c), wb_stall_out, starve_exp[c]);
        if (starve_exp[c]) begin
          exp_q.push_back({4'hF, 5'd12, 32'h0C0C_0C0C});
        end else begin
          exp_q.push_back({4'hF, 5'd3, 32'hB000_0000 + 32'(idx)});
          idx++;
        end
        tick();
      end
    end
    idle_inputs();
    check("starve_cnt_end", fifo_cnt_out, 2'd0);
    tick();

    // ---- fill to DEPTH, reject on full even with a pop, wrap over 6 pushes ----
    begin
      int n;
      n = 0;
      for (int c = 0; c < 9; c++) begin
        drive_wb(fills[c].wbv, 4'hF, 5'd24, 32'h0000_00A0 + 32'(c));
        md_valid_in = fills[c].mdv;
        md_wnum_in  = 5'd16 + 5'(n);
        md_wdata_in = 32'h5000_0000 + 32'(n);
        @(negedge clk);
        check($sformatf("fill_c%0d_ready", c), md_ready_out, fills[c].e_ready);
        check($sformatf("fill_c%0d_cnt", c), fifo_cnt_out, fills[c].e_cnt);
        check($sformatf("fill_c%0d_stall", c), wb_stall_out, 1'b0);
        if (fills[c].wbv) exp_q.push_back({4'hF, 5'd24, 32'h0000_00A0 + 32'(c)});
        if (fills[c].e_pop && md_model_q.size() > 0) exp_q.push_back({4'hF, md_model_q.pop_front()});
        if (fills[c].mdv && fills[c].e_ready) begin
          md_model_q.push_back({5'd16 + 5'(n), 32'h5000_0000 + 32'(n)});
          n++;
        end
        tick();
      end
    end
    idle_inputs();
    check("fill_cnt_end", fifo_cnt_out, 2'd0);
    tick();

    // ---- writes to r0 from both sides ----
    drive_wb(1'b1, 4'hF, 5'd0, 32'h0BAD_0BAD);
    md_valid_in = 1'b1; md_wnum_in = 5'd0; md_wdata_in = 32'hBAD0_BAD0;
    @(negedge clk);
    check("r0_stall", wb_stall_out, 1'b0);
    check("r0_ready", md_ready_out, 1'b1);
    tick();
    idle_inputs();
    check("r0_cnt", fifo_cnt_out, 2'd0);
    check("r0_no_write", rf_we_out, 4'h0);
    tick();
    check("r0_cnt_later", fifo_cnt_out, 2'd0);
    check("r0_no_write_later", rf_we_out, 4'h0);

    // ---- reset mid-operation with two queued entries ----
    drive_wb(1'b1, 4'hF, 5'd25, 32'h0000_0025);
    md_valid_in = 1'b1; md_wnum_in = 5'd26; md_wdata_in = 32'h2626_2626;
    exp_q.push_back({4'hF, 5'd25, 32'h0000_0025});
    tick();
    wb_wdata_in = 32'h0000_0026;
    md_wnum_in = 5'd27; md_wdata_in = 32'h2727_2727;
    exp_q.push_back({4'hF, 5'd25, 32'h0000_0026});
    tick();
    idle_inputs();
    id_rnum0_in = 5'd26;
    #1;
    check("rst_mid_cnt_before", fifo_cnt_out, 2'd2);
    check("rst_mid_hit_before", id_pending_hit_out, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_rf_we", rf_we_out, 4'h0);
    check("rst_mid_rf_wnum", rf_wnum_out, 5'd0);
    check("rst_mid_rf_wdata", rf_wdata_out, 32'd0);
    check("rst_mid_cnt", fifo_cnt_out, 2'd0);
    check("rst_mid_ready", md_ready_out, 1'b1);
    check("rst_mid_hit", id_pending_hit_out, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("rst_mid_cnt_after", fifo_cnt_out, 2'd0);
    check("rst_mid_no_write", rf_we_out, 4'h0);

    // ---- every expected write must have been observed ----
    check("exp_q_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
